// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I types and constants for the branch reservation station
package rv32i_types;
  localparam int BR_RS_DEPTH = 4;
  localparam int ROB_IDX_W = 5;
  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [ROB_IDX_W-1:0] rs1_tag;
    logic [ROB_IDX_W-1:0] rs2_tag;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
    logic [31:0]          rs1_data;
    logic [31:0]          rs2_data;
  } reservation_station_t;
endpackage

// File: rtl/br_rs_age_select.sv
// br_rs_age_select: one-hot grant of the oldest ready entry from an age matrix (older[j][i] = j older than i)
module br_rs_age_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        any_grant
);
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (ready[j] && older[j][i]) grant[i] = 1'b0;
    end
    any_grant = |ready;
  end
endmodule

// File: rtl/br_rs.sv
// br_rs: branch/jump reservation station with CDB wakeup and oldest-ready issue (BR_RS_PERF_EN adds perf counters)
module br_rs
  import rv32i_types::*;
#(
  parameter int DEPTH = BR_RS_DEPTH,
  parameter int CDB_PORTS = 2,
  parameter int ROB_IDX_W = rv32i_types::ROB_IDX_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                disp_valid,
  input  reservation_station_t                disp_entry,
  output logic                                rs_full,
  output logic [$clog2(DEPTH+1)-1:0]          rs_free_cnt,
  input  logic [CDB_PORTS-1:0]                cdb_valid,
  input  logic [CDB_PORTS-1:0][ROB_IDX_W-1:0] cdb_rob_idx,
  input  logic [CDB_PORTS-1:0][31:0]          cdb_data,
  input  logic                                flush,
  output reservation_station_t                next_execute
`ifdef BR_RS_PERF_EN
  ,
  output logic [31:0]                         perf_issue_cnt,
  output logic [31:0]                         perf_full_cyc,
  output logic [31:0]                         perf_wait_cyc
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  reservation_station_t rs_q [DEPTH];
  reservation_station_t rs_d [DEPTH];
  reservation_station_t dsp, iss;
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  logic [DEPTH-1:0] vld, rdy, gnt, free_oh;
  logic any, do_disp;
  function automatic reservation_station_t wake(
    input reservation_station_t                e,
    input logic [CDB_PORTS-1:0]                v,
    input logic [CDB_PORTS-1:0][ROB_IDX_W-1:0] t,
    input logic [CDB_PORTS-1:0][31:0]          d
  );
    wake = e;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (v[p] && !e.rs1_rdy && e.rs1_tag == t[p]) begin
        wake.rs1_rdy  = 1'b1;
        wake.rs1_data = d[p];
      end
      if (v[p] && !e.rs2_rdy && e.rs2_tag == t[p]) begin
        wake.rs2_rdy  = 1'b1;
        wake.rs2_data = d[p];
      end
    end
  endfunction
  br_rs_age_select #(.DEPTH(DEPTH)) u_sel (
    .ready     (rdy),
    .older     (older_q),
    .grant     (gnt),
    .any_grant (any)
  );
  always_comb begin
    rs_free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = rs_q[i].valid;
      rdy[i] = rs_q[i].valid && rs_q[i].rs1_rdy && rs_q[i].rs2_rdy;
      rs_free_cnt += CW'(!vld[i]);
    end
    rs_full = &vld;
    free_oh = ~vld & (vld + DEPTH'(1));
  end
  always_comb begin
    iss = '0;
    do_disp = disp_valid && !rs_full;
    dsp = wake(disp_entry, cdb_valid, cdb_rob_idx, cdb_data);
    dsp.valid = 1'b1;
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i]) iss = rs_q[i];
      rs_d[i] = rs_q[i].valid ? wake(rs_q[i], cdb_valid, cdb_rob_idx, cdb_data) : rs_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i]) begin
        rs_d[i].valid = 1'b0;
        older_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) older_d[j][i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_disp && free_oh[i]) begin
        rs_d[i] = dsp;
        older_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) older_d[j][i] = vld[j] && !gnt[j];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) rs_q[i] <= '0;
      older_q      <= '0;
      next_execute <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) rs_q[i] <= rs_d[i];
      older_q      <= older_d;
      next_execute <= any ? iss : '0;
    end
  end
`ifdef BR_RS_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_full_cyc  <= '0;
      perf_wait_cyc  <= '0;
    end else begin
      perf_issue_cnt <= perf_issue_cnt + 32'(any && !flush && !(&perf_issue_cnt));
      perf_full_cyc  <= perf_full_cyc + 32'(rs_full && disp_valid && !(&perf_full_cyc));
      perf_wait_cyc  <= perf_wait_cyc + 32'((|vld) && !any && !(&perf_wait_cyc));
    end
  end
`endif
`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (rst) !(disp_valid && rs_full))
    else $error("br_rs: dispatch while full, entry dropped");
`endif
endmodule

// File: tb/tb_br_rs.sv
// tb_br_rs: directed self-checking bench for br_rs
module tb_br_rs;
  import rv32i_types::*;
  logic clk = 1'b0;
  logic rst, disp_valid, flush, rs_full;
  reservation_station_t disp_entry, next_execute;
  logic [2:0] rs_free_cnt;
  logic [1:0] cdb_valid;
  logic [1:0][4:0] cdb_rob_idx;
  logic [1:0][31:0] cdb_data;
`ifdef BR_RS_PERF_EN
  logic [31:0] perf_issue_cnt, perf_full_cyc, perf_wait_cyc;
`endif
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  br_rs dut (
    .clk          (clk),
    .rst          (rst),
    .disp_valid   (disp_valid),
    .disp_entry   (disp_entry),
    .rs_full      (rs_full),
    .rs_free_cnt  (rs_free_cnt),
    .cdb_valid    (cdb_valid),
    .cdb_rob_idx  (cdb_rob_idx),
    .cdb_data     (cdb_data),
    .flush        (flush),
    .next_execute (next_execute)
`ifdef BR_RS_PERF_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_full_cyc  (perf_full_cyc),
    .perf_wait_cyc  (perf_wait_cyc)
`endif
  );
  function automatic reservation_station_t mk(input logic [31:0] pc, input logic r1, input logic [4:0] t1,
                                              input logic r2, input logic [4:0] t2);
    mk = '0;
    mk.pc = pc;
    mk.opcode = 7'b1100011;
    mk.rs1_rdy = r1;
    mk.rs1_tag = t1;
    mk.rs2_rdy = r2;
    mk.rs2_tag = t2;
    mk.rs1_data = 32'hDEAD_0001;
    mk.rs2_data = 32'hDEAD_0002;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    disp_valid = 1'b0;
    cdb_valid = '0;
    flush = 1'b0;
  endtask
  task automatic disp(input reservation_station_t e);
    disp_valid = 1'b1;
    disp_entry = e;
  endtask
  task automatic cdb(input int p, input logic [4:0] t, input logic [31:0] d);
    cdb_valid[p] = 1'b1;
    cdb_rob_idx[p] = t;
    cdb_data[p] = d;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    idle();
    disp_entry = '0;
    cdb_rob_idx = '0;
    cdb_data = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (next_execute !== '0) begin errs++; $display("FAIL reset_next_execute got %h want 0", next_execute); end
    checks++; if (rs_free_cnt !== 3'd4) begin errs++; $display("FAIL reset_free_cnt got %0d want 4", rs_free_cnt); end
    checks++; if (rs_full !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", rs_full); end
  endtask
  task automatic test_jal;
    disp(mk(32'h1000, 1'b1, 5'd0, 1'b1, 5'd0));
    tick();
    idle();
    checks++; if (rs_free_cnt !== 3'd3) begin errs++; $display("FAIL jal_free_after_disp got %0d want 3", rs_free_cnt); end
    checks++; if (next_execute.valid !== 1'b0) begin errs++; $display("FAIL jal_early_valid got %b want 0", next_execute.valid); end
    tick();
    checks++; if (next_execute.valid !== 1'b1) begin errs++; $display("FAIL jal_valid got %b want 1", next_execute.valid); end
    checks++; if (next_execute.pc !== 32'h1000) begin errs++; $display("FAIL jal_pc got %h want 00001000", next_execute.pc); end
    checks++; if (rs_free_cnt !== 3'd4) begin errs++; $display("FAIL jal_free_after_issue got %0d want 4", rs_free_cnt); end
    tick();
    checks++; if (next_execute.valid !== 1'b0) begin errs++; $display("FAIL jal_idle_valid got %b want 0", next_execute.valid); end
  endtask
  task automatic test_wakeup;
    disp(mk(32'h2000, 1'b0, 5'd3, 1'b1, 5'd0));
    tick();
    disp(mk(32'h2004, 1'b1, 5'd0, 1'b1, 5'd0));
    tick();
    idle();
    checks++; if (next_execute.valid !== 1'b0) begin errs++; $display("FAIL wake_beq_not_ready got %b want 0", next_execute.valid); end
    tick();
    checks++; if (next_execute.valid !== 1'b1 || next_execute.pc !== 32'h2004) begin errs++; $display("FAIL wake_bne_first got v=%b pc=%h want v=1 pc=00002004", next_execute.valid, next_execute.pc); end
    cdb(0, 5'd3, 32'h5);
    tick();
    idle();
    checks++; if (next_execute.valid !== 1'b0) begin errs++; $display("FAIL wake_same_cycle_issue got %b want 0", next_execute.valid); end
    tick();
    checks++; if (next_execute.valid !== 1'b1 || next_execute.pc !== 32'h2000) begin errs++; $display("FAIL wake_beq_issue got v=%b pc=%h want v=1 pc=00002000", next_execute.valid, next_execute.pc); end
    checks++; if (next_execute.rs1_data !== 32'h5) begin errs++; $display("FAIL wake_beq_data got %h want 00000005", next_execute.rs1_data); end
    checks++; if (next_execute.rs2_data !== 32'hDEAD_0002) begin errs++; $display("FAIL wake_beq_rs2_kept got %h want dead0002", next_execute.rs2_data); end
    tick();
  endtask
  task automatic test_same_cycle;
    disp(mk(32'h3000, 1'b0, 5'd7, 1'b1, 5'd0));
    cdb(1, 5'd7, 32'hFFFF_FFFF);
    cdb(0, 5'd8, 32'h1);
    tick();
    idle();
    checks++; if (next_execute.valid !== 1'b0) begin errs++; $display("FAIL same_early got %b want 0", next_execute.valid); end
    tick();
    checks++; if (next_execute.valid !== 1'b1 || next_execute.pc !== 32'h3000) begin errs++; $display("FAIL same_issue got v=%b pc=%h want v=1 pc=00003000", next_execute.valid, next_execute.pc); end
    checks++; if (next_execute.rs1_data !== 32'hFFFF_FFFF) begin errs++; $display("FAIL same_data got %h want ffffffff", next_execute.rs1_data); end
    tick();
  endtask
  task automatic test_port_priority;
    disp(mk(32'h3100, 1'b0, 5'd4, 1'b1, 5'd0));
    tick();
    idle();
    cdb(0, 5'd4, 32'h11);
    cdb(1, 5'd4, 32'h22);
    tick();
    idle();
    tick();
    checks++; if (next_execute.valid !== 1'b1 || next_execute.rs1_data !== 32'h11) begin errs++; $display("FAIL prio_data got v=%b d=%h want v=1 d=00000011", next_execute.valid, next_execute.rs1_data); end
    tick();
  endtask
  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      disp(mk(32'h4000 + 32'(4 * i), 1'b0, 5'd10, 1'b1, 5'd0));
      tick();
    end
    idle();
    checks++; if (rs_full !== 1'b1 || rs_free_cnt !== 3'd0) begin errs++; $display("FAIL fill_full got full=%b free=%0d want full=1 free=0", rs_full, rs_free_cnt); end
    cdb(0, 5'd10, 32'hAB);
    tick();
    idle();
    checks++; if (rs_full !== 1'b1) begin errs++; $display("FAIL fill_still_full got %b want 1", rs_full); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (next_execute.valid !== 1'b1 || next_execute.pc !== 32'h4000 + 32'(4 * i)) begin errs++; $display("FAIL fill_order%0d got v=%b pc=%h want v=1 pc=%h", i, next_execute.valid, next_execute.pc, 32'h4000 + 32'(4 * i)); end
      if (i == 0) begin
        checks++; if (rs_full !== 1'b0 || rs_free_cnt !== 3'd1) begin errs++; $display("FAIL fill_deassert got full=%b free=%0d want full=0 free=1", rs_full, rs_free_cnt); end
      end
    end
    tick();
    checks++; if (rs_free_cnt !== 3'd4) begin errs++; $display("FAIL fill_drained got %0d want 4", rs_free_cnt); end
  endtask
  task automatic test_flush;
    disp(mk(32'h6000, 1'b0, 5'd15, 1'b1, 5'd0));
    tick();
    disp(mk(32'h6004, 1'b0, 5'd15, 1'b1, 5'd0));
    tick();
    disp(mk(32'h6008, 1'b1, 5'd0, 1'b1, 5'd0));
    tick();
    checks++; if (rs_free_cnt !== 3'd1) begin errs++; $display("FAIL flush_held got %0d want 1", rs_free_cnt); end
    disp(mk(32'h600C, 1'b1, 5'd0, 1'b1, 5'd0));
    flush = 1'b1;
    tick();
    idle();
    checks++; if (rs_free_cnt !== 3'd4) begin errs++; $display("FAIL flush_free got %0d want 4", rs_free_cnt); end
    checks++; if (next_execute.valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %b want 0", next_execute.valid); end
    cdb(0, 5'd15, 32'h77);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (next_execute.valid !== 1'b0 || rs_free_cnt !== 3'd4) begin errs++; $display("FAIL flush_no_issue%0d got v=%b free=%0d want v=0 free=4", i, next_execute.valid, rs_free_cnt); end
      tick();
    end
  endtask
  task automatic test_same_wake;
    disp(mk(32'h5000, 1'b1, 5'd0, 1'b1, 5'd0));
    tick();
    disp(mk(32'h5004, 1'b0, 5'd2, 1'b1, 5'd0));
    tick();
    checks++; if (next_execute.valid !== 1'b1 || next_execute.pc !== 32'h5000) begin errs++; $display("FAIL age_first got v=%b pc=%h want v=1 pc=00005000", next_execute.valid, next_execute.pc); end
    disp(mk(32'h5008, 1'b0, 5'd9, 1'b1, 5'd0));
    tick();
    idle();
    cdb(0, 5'd2, 32'h22);
    cdb(1, 5'd9, 32'h99);
    tick();
    idle();
    checks++; if (next_execute.valid !== 1'b0) begin errs++; $display("FAIL age_wake_cycle got %b want 0", next_execute.valid); end
    tick();
    checks++; if (next_execute.pc !== 32'h5004 || next_execute.rs1_data !== 32'h22) begin errs++; $display("FAIL age_older got pc=%h d=%h want pc=00005004 d=00000022", next_execute.pc, next_execute.rs1_data); end
    tick();
    checks++; if (next_execute.valid !== 1'b1 || next_execute.pc !== 32'h5008 || next_execute.rs1_data !== 32'h99) begin errs++; $display("FAIL age_younger got v=%b pc=%h d=%h want v=1 pc=00005008 d=00000099", next_execute.valid, next_execute.pc, next_execute.rs1_data); end
    tick();
  endtask
  task automatic test_mid_reset;
    disp(mk(32'h7000, 1'b1, 5'd0, 1'b1, 5'd0));
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (next_execute !== '0 || rs_free_cnt !== 3'd4) begin errs++; $display("FAIL midrst got ne=%h free=%0d want 0 and 4", next_execute, rs_free_cnt); end
    tick();
    checks++; if (next_execute.valid !== 1'b0) begin errs++; $display("FAIL midrst_after got %b want 0", next_execute.valid); end
  endtask
  initial begin
    test_reset();
    test_jal();
    test_wakeup();
    test_same_cycle();
    test_port_priority();
    test_fill();
    test_flush();
    test_same_wake();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
